// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding, load-use hazard bubbles and bubble counting
module id_ex_stage #(
   parameter int DATA_W = 16,
   parameter int OP_W = 4,
   parameter int REG_W = 4,
   parameter logic [REG_W-1:0] NOREG = 4'hF,
   parameter logic [OP_W-1:0] OP_NOP = 4'hE
) (
   input  logic clk,
   input  logic rst,
   input  logic stall,
   input  logic flush,
   input  logic [DATA_W-1:0] id_a,
   input  logic [DATA_W-1:0] id_b,
   input  logic [REG_W-1:0] id_rs_a,
   input  logic [REG_W-1:0] id_rs_b,
   input  logic [OP_W-1:0] id_op,
   input  logic [REG_W-1:0] id_wreg,
   input  logic id_we,
   input  logic id_mem_rd,
   input  logic id_mem_wr,
   input  logic [REG_W-1:0] exmem_wreg,
   input  logic exmem_we,
   input  logic [DATA_W-1:0] exmem_data,
   input  logic [REG_W-1:0] memwb_wreg,
   input  logic memwb_we,
   input  logic [DATA_W-1:0] memwb_data,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0] alu_op,
   output logic [REG_W-1:0] ex_wreg,
   output logic ex_we,
   output logic ex_mem_rd,
   output logic ex_mem_wr,
   output logic [DATA_W-1:0] ex_store_data,
   output logic stall_req,
   output logic [15:0] bubble_cnt
);
   logic [DATA_W-1:0] a_q, b_q;
   logic [REG_W-1:0] rs_a_q, rs_b_q, wreg_q;
   logic [OP_W-1:0] op_q;
   logic we_q, mem_rd_q, mem_wr_q;
   logic bubble, counted;

   // a load in EX whose destination feeds either ID source must wait one cycle
   always_comb begin
      stall_req = mem_rd_q && wreg_q != NOREG && (id_rs_a == wreg_q || id_rs_b == wreg_q);
      counted = flush || (!stall && stall_req);
      bubble = !rst || counted;
   end

   // pipeline register: reset/flush/hazard load a bubble, stall holds, otherwise capture ID
   always_ff @(posedge clk) begin
      if (bubble) begin
         a_q <= '0;
         b_q <= '0;
         rs_a_q <= NOREG;
         rs_b_q <= NOREG;
         op_q <= OP_NOP;
         wreg_q <= NOREG;
         we_q <= 1'b0;
         mem_rd_q <= 1'b0;
         mem_wr_q <= 1'b0;
      end else if (!stall) begin
         a_q <= id_a;
         b_q <= id_b;
         rs_a_q <= id_rs_a;
         rs_b_q <= id_rs_b;
         op_q <= id_op;
         wreg_q <= id_wreg;
         we_q <= id_we;
         mem_rd_q <= id_mem_rd;
         mem_wr_q <= id_mem_wr;
      end
   end

   // count only flush- and hazard-induced bubbles, wrapping naturally
   always_ff @(posedge clk) begin
      if (!rst) bubble_cnt <= '0;
      else if (counted) bubble_cnt <= bubble_cnt + 16'd1;
   end

   // forwarding: EX/MEM result beats MEM/WB, immediates (NOREG) never forward
   always_comb begin
      alu_a = (rs_a_q != NOREG && exmem_we && exmem_wreg == rs_a_q) ? exmem_data :
              (rs_a_q != NOREG && memwb_we && memwb_wreg == rs_a_q) ? memwb_data : a_q;
      alu_b = (rs_b_q != NOREG && exmem_we && exmem_wreg == rs_b_q) ? exmem_data :
              (rs_b_q != NOREG && memwb_we && memwb_wreg == rs_b_q) ? memwb_data : b_q;
      ex_store_data = alu_b;
      alu_op = op_q;
      ex_wreg = wreg_q;
      ex_we = we_q;
      ex_mem_rd = mem_rd_q;
      ex_mem_wr = mem_wr_q;
   end
endmodule
